// File: rtl/bitonic_drain.sv
// bitonic_drain: captures one sorted NUM x W vector from the bitonic sorter
// and streams its elements out one per beat, element 0 first, over a
// valid/ready interface.
// Optional feature: define BITONIC_DRAIN_ORDER_CHECK_EN to check, at each
// capture, that the vector obeys its declared order (sticky order_err).
// Without the macro order_err is tied low and no comparators exist.
module bitonic_drain #(
  parameter int NUM = 4,
  parameter int W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    direction,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM*W-1:0]        IN,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W-1:0]            out_data,
  output logic [$clog2(NUM)-1:0]  out_index,
  output logic                    out_last,
  output logic                    order_err
);

  localparam int IDX_W = $clog2(NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t             state;
  logic [NUM*W-1:0]   data_buf;
  logic [IDX_W-1:0]   idx;

  logic at_last;
  logic beat;
  logic capture;

  assign at_last = (idx == LAST_IDX);
  assign beat    = out_valid & out_ready;

  // A new vector may enter while idle, or on the very cycle the last
  // element of the current vector is popped (zero-bubble back-to-back).
  assign in_ready = (state == IDLE) | ((state == DRAIN) & at_last & out_ready);
  assign capture  = in_valid & in_ready;

  assign out_valid = (state == DRAIN);
  assign out_data  = data_buf[int'(idx)*W +: W];
  assign out_index = idx;
  assign out_last  = (state == DRAIN) & at_last;

  // Drain FSM: capture a vector, then step idx once per accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      data_buf <= '0;
      idx      <= '0;
    end else if (capture) begin
      // Covers both the idle capture and the last-beat reload.
      state    <= DRAIN;
      data_buf <= IN;
      idx      <= '0;
    end else if (beat) begin
      if (at_last) begin
        state <= IDLE;
        idx   <= '0;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

`ifdef BITONIC_DRAIN_ORDER_CHECK_EN
  logic violation;

  // Any adjacent pair out of its declared order flags the presented vector.
  always_comb begin
    violation = 1'b0;
    for (int i = 0; i < NUM - 1; i++) begin
      if (direction ? (IN[i*W +: W] > IN[(i+1)*W +: W])
                    : (IN[i*W +: W] < IN[(i+1)*W +: W]))
        violation = 1'b1;
    end
  end

  // Sticky error: set at the capture edge, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      order_err <= 1'b0;
    else if (capture && violation)
      order_err <= 1'b1;
  end
`else
  // Order is only meaningful to the checker; without it direction is dropped.
  logic unused_direction;
  assign unused_direction = direction;
  assign order_err        = 1'b0;
`endif

endmodule

// File: tb/tb_bitonic_drain.sv
// Directed self-checking bench for bitonic_drain (NUM=4, W=16).
module tb_bitonic_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        direction;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_vec;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_index;
  logic        out_last;
  logic        order_err;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef BITONIC_DRAIN_ORDER_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  localparam logic [63:0] VEC_A = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
  localparam logic [63:0] VEC_B = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
  localparam logic [63:0] VEC_D = {16'h0001, 16'h0005, 16'h0009, 16'h0007};

  logic [15:0] exp_a [4] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
  logic [15:0] exp_ab[8] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040,
                             16'h0001, 16'h0002, 16'h0003, 16'h0004};
  logic [15:0] exp_d [4] = '{16'h0007, 16'h0009, 16'h0005, 16'h0001};
  logic        pat   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  bitonic_drain #(.NUM(4), .W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .direction (direction),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .IN        (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .order_err (order_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int nb;
    rst       = 1'b1;
    direction = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_index", 32'(out_index), 32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    chk("rst_order_err", 32'(order_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic drain
    @(negedge clk);
    in_vec = VEC_A; direction = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("basic_valid", 32'(out_valid), 32'd1);
      chk("basic_data",  32'(out_data),  32'(exp_a[i]));
      chk("basic_index", 32'(out_index), 32'(i));
      chk("basic_last",  32'(out_last),  32'(i == 3));
      chk("basic_ready", 32'(in_ready),  32'(i == 3));
      @(negedge clk);
    end
    chk("basic_done_valid", 32'(out_valid), 32'd0);
    chk("basic_done_ready", 32'(in_ready),  32'd1);
    chk("basic_order_err",  32'(order_err), 32'd0);

    // Back-pressure
    in_vec = VEC_A; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    nb = 0;
    for (int k = 0; k < 7; k++) begin
      out_ready = pat[k];
      #1;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data",  32'(out_data),  32'(exp_a[nb]));
      chk("bp_index", 32'(out_index), 32'(nb));
      chk("bp_ready", 32'(in_ready),  32'((nb == 3) && pat[k]));
      if (pat[k]) nb++;
      @(negedge clk);
    end
    chk("bp_done_valid", 32'(out_valid), 32'd0);

    // Back-to-back, IN changed mid-drain
    in_vec = VEC_A; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_vec = VEC_B;
    for (int j = 0; j < 8; j++) begin
      if (j == 4) in_valid = 1'b0;
      #1;
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_data",  32'(out_data),  32'(exp_ab[j]));
      chk("b2b_index", 32'(out_index), 32'(j % 4));
      chk("b2b_last",  32'(out_last),  32'((j % 4) == 3));
      chk("b2b_ready", 32'(in_ready),  32'((j % 4) == 3));
      @(negedge clk);
    end
    chk("b2b_done_valid", 32'(out_valid), 32'd0);

    // Descending vector with an order violation
    chk("desc_err_before", 32'(order_err), 32'd0);
    in_vec = VEC_D; direction = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("desc_err_capture", 32'(order_err), 32'(EXP_ERR));
    for (int i = 0; i < 4; i++) begin
      chk("desc_valid", 32'(out_valid), 32'd1);
      chk("desc_data",  32'(out_data),  32'(exp_d[i]));
      @(negedge clk);
    end
    in_vec = VEC_A; direction = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("desc_next_data", 32'(out_data), 32'(exp_a[i]));
      @(negedge clk);
    end
    chk("desc_err_sticky", 32'(order_err), 32'(EXP_ERR));

    // Reset mid-drain
    in_vec = VEC_A; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_index_before", 32'(out_index), 32'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid",  32'(out_valid), 32'd0);
    chk("mid_rst_ready",  32'(in_ready),  32'd1);
    chk("mid_rst_index",  32'(out_index), 32'd0);
    chk("mid_rst_data",   32'(out_data),  32'd0);
    chk("mid_rst_err",    32'(order_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mid_post_valid", 32'(out_valid), 32'd0);
      chk("mid_post_ready", 32'(in_ready),  32'd1);
    end

    // Idle hold
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("idle_ready", 32'(in_ready),  32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
